// File: rtl/pipe_stage_skid_if.sv
// Valid/ready stream bundle carrying control bits and payload between pipeline stages.
// The producer drives valid/ctrl/data through master; the consumer drives ready through slave.
interface pipe_stage_skid_if #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 192
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, ctrl, data, input ready);
    modport slave  (input valid, ctrl, data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, flush, an optional 2-entry skid buffer
// and a saturating back-pressure counter. An empty stage presents all-zero control bits.
module pipe_stage_skid #(
    parameter int DATA_W   = 192,
    parameter int CTRL_W   = 16,
    parameter int SKID     = 1,
    parameter int CLR_DATA = 1,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    pipe_stage_skid_if.slave   in_if,
    pipe_stage_skid_if.master  out_if,
    output logic [1:0]         occupancy,
    output logic [CNT_W-1:0]   stall_cnt
);
    // Encoding equals the entry count so occupancy comes straight from the state flop.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic out_valid;
    logic in_ready;
    logic in_fire;
    logic out_fire;

    assign out_valid = (state_q != ST_EMPTY);

    always_comb begin
        in_ready = (SKID != 0) ? in_ready_q : (out_if.ready | ~out_valid);
    end

    assign in_fire  = in_if.valid & in_ready;
    assign out_fire = out_valid & out_if.ready;

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            // Payload regs are left alone so a CLR_DATA=0 stage keeps showing its last value.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d     = ST_ONE;
                        main_ctrl_d = in_if.ctrl;
                        main_data_d = in_if.data;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_ctrl_d = in_if.ctrl;
                        main_data_d = in_if.data;
                    end else if (in_fire && (SKID != 0)) begin
                        state_d     = ST_TWO;
                        skid_ctrl_d = in_if.ctrl;
                        skid_data_d = in_if.data;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        state_d     = ST_ONE;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        in_ready_d = (state_d != ST_TWO);
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_if.ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign in_if.ready  = in_ready;
    assign out_if.valid = out_valid;
    assign out_if.ctrl  = out_valid ? main_ctrl_q : '0;
    assign out_if.data  = (out_valid || (CLR_DATA == 0)) ? main_data_q : '0;
    assign occupancy    = state_q;
    assign stall_cnt    = stall_cnt_q;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a skid stage, a single-entry stage and a
// narrow-counter hold-data stage share one clock and reset.
module tb_pipe_stage_skid;
    logic clk;
    logic reset;
    logic fl_a, fl_b, fl_c;
    logic [1:0]  a_occ, b_occ, c_occ;
    logic [15:0] a_stall, b_stall;
    logic [3:0]  c_stall;
    int n_chk = 0;
    int n_err = 0;

    pipe_stage_skid_if #(.CTRL_W(8), .DATA_W(32)) a_in (), a_out (), b_in (), b_out (), c_in (), c_out ();

    pipe_stage_skid #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CLR_DATA(1), .CNT_W(16)) u_a (
        .clk(clk), .reset(reset), .flush(fl_a), .in_if(a_in), .out_if(a_out),
        .occupancy(a_occ), .stall_cnt(a_stall));
    pipe_stage_skid #(.DATA_W(32), .CTRL_W(8), .SKID(0), .CLR_DATA(1), .CNT_W(16)) u_b (
        .clk(clk), .reset(reset), .flush(fl_b), .in_if(b_in), .out_if(b_out),
        .occupancy(b_occ), .stall_cnt(b_stall));
    pipe_stage_skid #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CLR_DATA(0), .CNT_W(4)) u_c (
        .clk(clk), .reset(reset), .flush(fl_c), .in_if(c_in), .out_if(c_out),
        .occupancy(c_occ), .stall_cnt(c_stall));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        fl_a = 1'b0; fl_b = 1'b0; fl_c = 1'b0;
        a_in.valid = 0; a_in.ctrl = 0; a_in.data = 0; a_out.ready = 1;
        b_in.valid = 0; b_in.ctrl = 0; b_in.data = 0; b_out.ready = 1;
        c_in.valid = 0; c_in.ctrl = 0; c_in.data = 0; c_out.ready = 1;

        // reset with random activity on the inputs
        for (int i = 0; i < 4; i++) begin
            a_in.valid = 1'($urandom); a_in.ctrl = 8'($urandom); a_in.data = $urandom;
            a_out.ready = 1'($urandom); fl_a = 1'($urandom);
            b_in.valid = 1'($urandom); b_in.data = $urandom; b_out.ready = 1'($urandom);
            c_in.valid = 1'($urandom); c_in.data = $urandom; c_out.ready = 1'($urandom);
            tick;
            chk("rst_vld", a_out.valid, 0);
            chk("rst_ctrl", a_out.ctrl, 0);
            chk("rst_data", a_out.data, 0);
            chk("rst_occ", a_occ, 0);
            chk("rst_stall", a_stall, 0);
            chk("rst_rdy_a", a_in.ready, 1);
            chk("rst_rdy_b", b_in.ready, 1);
            chk("rst_data_c", c_out.data, 0);
        end
        a_in.valid = 0; a_out.ready = 1; fl_a = 0;
        b_in.valid = 0; b_out.ready = 1;
        c_in.valid = 0; c_out.ready = 1;
        reset = 1'b1;
        tick;

        // streaming 1..8 with out_ready=1
        for (int i = 1; i <= 8; i++) begin
            a_in.valid = 1; a_in.ctrl = 8'(i); a_in.data = 32'(i);
            #1 chk("str_rdy", a_in.ready, 1);
            tick;
            chk("str_vld", a_out.valid, 1);
            chk("str_data", a_out.data, 64'(i));
            chk("str_ctrl", a_out.ctrl, 64'(i));
        end
        a_in.valid = 0;
        tick;
        chk("str_end_vld", a_out.valid, 0);
        chk("str_end_ctrl", a_out.ctrl, 0);
        chk("str_end_data", a_out.data, 0);
        chk("str_end_occ", a_occ, 0);

        // back-pressure: A, then B and C offered while out_ready=0
        a_in.valid = 1; a_in.ctrl = 8'h0A; a_in.data = 32'hA; a_out.ready = 1;
        tick;
        chk("bp_a", a_out.data, 32'hA);
        a_in.ctrl = 8'h0B; a_in.data = 32'hB; a_out.ready = 0;
        tick;
        chk("bp_occ2", a_occ, 2);
        chk("bp_rdy0", a_in.ready, 0);
        chk("bp_hold_a", a_out.data, 32'hA);
        a_in.ctrl = 8'h0C; a_in.data = 32'hC;
        tick;
        tick;
        chk("bp_occ2b", a_occ, 2);
        chk("bp_hold_a2", a_out.data, 32'hA);
        a_out.ready = 1;
        tick;
        chk("bp_b", a_out.data, 32'hB);
        chk("bp_occ1", a_occ, 1);
        chk("bp_rdy1", a_in.ready, 1);
        tick;
        chk("bp_c", a_out.data, 32'hC);
        chk("bp_c_ctrl", a_out.ctrl, 8'h0C);
        a_in.valid = 0;
        tick;
        chk("bp_empty", a_occ, 0);
        chk("bp_stall", a_stall, 3);

        // flush from two entries, D offered
        a_in.valid = 1; a_in.ctrl = 8'h21; a_in.data = 32'h21; a_out.ready = 0;
        tick;
        a_in.ctrl = 8'h22; a_in.data = 32'h22;
        tick;
        chk("fl_occ2", a_occ, 2);
        fl_a = 1; a_in.ctrl = 8'hDD; a_in.data = 32'hDD;
        tick;
        chk("fl_vld", a_out.valid, 0);
        chk("fl_ctrl", a_out.ctrl, 0);
        chk("fl_occ", a_occ, 0);
        chk("fl_stall", a_stall, 5);
        fl_a = 0; a_in.valid = 0;
        tick;
        chk("fl_still_empty", a_out.valid, 0);
        // flush from one entry while D actually fires
        a_in.valid = 1; a_in.ctrl = 8'h31; a_in.data = 32'h31;
        tick;
        fl_a = 1; a_in.ctrl = 8'hDD; a_in.data = 32'hDD;
        #1 chk("fl1_rdy", a_in.ready, 1);
        tick;
        fl_a = 0; a_in.valid = 0; a_out.ready = 1;
        chk("fl1_occ", a_occ, 0);
        tick;
        chk("fl1_d_drop", a_out.valid, 0);
        chk("fl1_stall", a_stall, 6);

        // single-entry stage: combinational ready and replace without bubble
        b_in.valid = 1; b_in.ctrl = 8'h51; b_in.data = 32'h51;
        tick;
        b_out.ready = 0; b_in.ctrl = 8'h52; b_in.data = 32'h52;
        #1 chk("s0_rdy0", b_in.ready, 0);
        tick;
        chk("s0_hold", b_out.data, 32'h51);
        chk("s0_stall", b_stall, 1);
        b_out.ready = 1;
        #1 chk("s0_rdy1", b_in.ready, 1);
        tick;
        chk("s0_repl_vld", b_out.valid, 1);
        chk("s0_repl", b_out.data, 32'h52);
        b_in.ctrl = 8'h53; b_in.data = 32'h53;
        tick;
        chk("s0_repl2", b_out.data, 32'h53);
        b_in.valid = 0;
        tick;
        chk("s0_empty", b_out.valid, 0);
        chk("s0_ctrl0", b_out.ctrl, 0);

        // saturation with a 4-bit counter, then a hold-data bubble
        c_in.valid = 1; c_in.ctrl = 8'h6F; c_in.data = 32'h61; c_out.ready = 0;
        tick;
        c_in.valid = 0;
        for (int i = 1; i <= 20; i++) begin
            tick;
            chk("sat_cnt", c_stall, (i > 15) ? 15 : i);
        end
        chk("sat_data", c_out.data, 32'h61);
        c_out.ready = 1;
        tick;
        chk("cd0_vld", c_out.valid, 0);
        chk("cd0_ctrl", c_out.ctrl, 0);
        chk("cd0_data", c_out.data, 32'h61);
        chk("cd0_stall", c_stall, 15);

        // asynchronous reset with an entry held, then normal accept
        a_in.valid = 1; a_in.ctrl = 8'h71; a_in.data = 32'h71; a_out.ready = 0;
        tick;
        chk("mr_vld1", a_out.valid, 1);
        a_in.valid = 0;
        #2 reset = 1'b0;
        #1;
        chk("mr_vld0", a_out.valid, 0);
        chk("mr_occ", a_occ, 0);
        chk("mr_stall", a_stall, 0);
        reset = 1'b1;
        a_in.valid = 1; a_in.ctrl = 8'h72; a_in.data = 32'h72; a_out.ready = 1;
        tick;
        chk("mr_accept", a_out.data, 32'h72);
        chk("mr_accept_vld", a_out.valid, 1);
        a_in.valid = 0;
        tick;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
